// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the round datapath stages.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [7:0]   aes_byte_t;

    localparam int        NR_AES128 = 10;
    localparam aes_byte_t RCON_INIT = 8'h01;
    localparam aes_byte_t GF_POLY   = 8'h1b;

    typedef enum logic [1:0] {
        ARK_IDLE  = 2'd0,
        ARK_RUN   = 2'd1,
        ARK_DRAIN = 2'd2
    } ark_fsm_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_subword.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word (also usable by SubBytes).
module key_subword
    import aes_pkg::*;
(
    input  aes_word_t word,
    output aes_word_t subword
);

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic aes_byte_t sbox(input aes_byte_t b);
        return SBOX[b];
    endfunction

    assign subword = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/addroundkey_stage.sv
// Registered AddRoundKey stage with an on-the-fly AES-128 key schedule.
// Build option ADDROUNDKEY_ZEROIZE_EN: clear the round-key register when done pulses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARK_IDLE  | no block armed; beats are ignored
// ARK_RUN   | accepting beats for rounds 0..NR, key advances per beat
// ARK_DRAIN | round-NR beat accepted, waiting for its output handshake
module addroundkey_stage
    import aes_pkg::*;
#(
    parameter int NR    = NR_AES128,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] state,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] outputstate,
    output logic [3:0]       round,
    output logic             done
);

    ark_fsm_t   fsm;
    aes_state_t rk;
    aes_byte_t  rcon;
    aes_word_t  rot_w;
    aes_word_t  sub_w;
    aes_word_t  t_w;
    aes_word_t  w0_n;
    aes_word_t  w1_n;
    aes_word_t  w2_n;
    aes_word_t  w3_n;
    aes_state_t rk_next;
    logic       accept;
    logic       last_round;

    assign rot_w = rot_word(rk[31:0]);

    key_subword u_key_subword (
        .word    (rot_w),
        .subword (sub_w)
    );

    // Next round key is combinational from the registered key, so the beat
    // accepted this cycle always sees the key for its own round.
    always_comb begin
        t_w     = sub_w ^ {rcon, 24'h000000};
        w0_n    = rk[127:96] ^ t_w;
        w1_n    = rk[95:64]  ^ w0_n;
        w2_n    = rk[63:32]  ^ w1_n;
        w3_n    = rk[31:0]   ^ w2_n;
        rk_next = {w0_n, w1_n, w2_n, w3_n};
    end

    assign in_ready   = (fsm == ARK_RUN) && (!out_valid || out_ready) && !start;
    assign accept     = in_valid && in_ready;
    assign last_round = (round == 4'(NR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= ARK_IDLE;
            round       <= '0;
            rcon        <= RCON_INIT;
            rk          <= '0;
            outputstate <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Restart discards any output still waiting downstream.
                fsm       <= ARK_RUN;
                rk        <= key;
                round     <= '0;
                rcon      <= RCON_INIT;
                out_valid <= 1'b0;
            end else if (accept) begin
                outputstate <= state ^ rk;
                out_valid   <= 1'b1;
                if (last_round) begin
                    fsm <= ARK_DRAIN;
                end else begin
                    rk    <= rk_next;
                    round <= round + 4'd1;
                    rcon  <= xtime(rcon);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (fsm == ARK_DRAIN) begin
                    fsm  <= ARK_IDLE;
                    done <= 1'b1;
`ifdef ADDROUNDKEY_ZEROIZE_EN
                    rk   <= '0;
`else
                    rk   <= rk;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_addroundkey_stage.sv
// Randomized scoreboard bench for addroundkey_stage against a FIPS-197 key-expansion model.
module tb_addroundkey_stage;

    localparam int NR = 10;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] STATE_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] EXP_B   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] RK1_B   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] outputstate;
    logic [3:0]   round;
    logic         done;

    addroundkey_stage dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .state       (state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .outputstate (outputstate),
        .round       (round),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [127:0] data;
        int           tag;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0]   sbox_t [256];
    logic [127:0] mdl_rk [0:10];
    logic [127:0] got_out [0:10];
    int           exp_round = 0;
    bit           running = 1'b0;
    bit           m_ov = 1'b0;
    bit           done_due = 1'b0;
    int           hs_cnt = 0;
    int           done_cnt = 0;
    int           ready_mode = 2;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_os = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic compute_keys(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mdl_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(1));
            default: out_ready = 1'b0;
        endcase
    end

    // Input side: round/in_ready model and expected-value push on each accept.
    always @(negedge clk) begin
        if (rst) begin
            exp_round = 0;
            running   = 1'b0;
        end else begin
            chk("round", 128'(round), 128'(exp_round));
            chk("in_ready", 128'(in_ready), 128'(running && (!out_valid || out_ready) && !start));
            if (start) begin
                compute_keys(key);
                exp_round = 0;
                running   = 1'b1;
            end else if (in_valid && in_ready) begin
                exp_q.push_back('{state ^ mdl_rk[exp_round], exp_round});
                if (exp_round == NR) running = 1'b0;
                else exp_round++;
            end
        end
    end

    // Output side: pop and compare on every output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            m_ov       = 1'b0;
            done_due   = 1'b0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            chk("out_valid", 128'(out_valid), 128'(m_ov));
            chk("done", 128'(done), 128'(done_due));
            if (done) done_cnt++;
            done_due = 1'b0;
            if (prev_stall && out_valid) chk("stall_hold", outputstate, prev_os);
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL outputstate: got %h with no beat expected at %0t", outputstate, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("outputstate", outputstate, e.data);
                    got_out[e.tag] = outputstate;
                    if (e.tag == NR && !start) done_due = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready && !start;
            prev_os    = outputstate;
            if (start)                        m_ov = 1'b0;
            else if (in_valid && in_ready)    m_ov = 1'b1;
            else if (out_valid && out_ready)  m_ov = 1'b0;
            if (start) exp_q.delete();
        end
    end

    task automatic do_start(input logic [127:0] k, output int hs_base);
        start = 1'b1;
        key   = k;
        @(posedge clk); #1;
        start   = 1'b0;
        hs_base = hs_cnt;
    endtask

    task automatic feed(input int n, input int vpct, input bit zero, input int maxcyc, output int acc);
        acc = 0;
        for (int cyc = 0; cyc < maxcyc && acc < n; cyc++) begin
            in_valid = ($urandom_range(99) < vpct);
            state    = zero ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic feed_one(input logic [127:0] s);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        state    = s;
        for (int cyc = 0; cyc < 50 && !ok; cyc++) begin
            @(negedge clk);
            ok = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("feed_one_accepted", 128'(ok), 128'(1));
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            seen = done;
        end
        @(posedge clk); #1;
        chk("done_seen", 128'(seen), 128'(1));
    endtask

    initial begin
        int acc;
        int hb;
        int dc;
        build_sbox();

        #12;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_outputstate", outputstate, 128'(0));
        chk("rst_round", 128'(round), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rk", dut.rk, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;
        @(posedge clk); #1;

        // FIPS-197 B round-0 vector
        do_start(KEY_B, hb);
        feed_one(STATE_B);
        @(posedge clk); #1;
        chk("b_vector_round0", got_out[0], EXP_B);

        // Key schedule walk with all-zero beats
        dc = done_cnt;
        do_start(KEY_B, hb);
        feed(11, 100, 1'b1, 100, acc);
        chk("walk_accepts", 128'(acc), 128'(11));
        wait_done();
        chk("walk_rk1", got_out[1], RK1_B);
        chk("walk_rk10", got_out[10], RK10_B);
        chk("walk_handshakes", 128'(hs_cnt - hb), 128'(11));
`ifdef ADDROUNDKEY_ZEROIZE_EN
        chk("rk_zeroized", dut.rk, 128'(0));
`else
        chk("rk_retained", dut.rk, RK10_B);
`endif
        feed(3, 100, 1'b0, 6, acc);
        chk("idle_beats_ignored", 128'(acc), 128'(0));
        chk("idle_outputstate_held", outputstate, RK10_B);
        chk("idle_round_held", 128'(round), 128'(NR));
        chk("walk_done_once", 128'(done_cnt - dc), 128'(1));

        // Full throughput: 11 beats in 11 consecutive cycles
        do_start({$urandom, $urandom, $urandom, $urandom}, hb);
        acc = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("throughput_accepts", 128'(acc), 128'(11));
        wait_done();
        chk("throughput_handshakes", 128'(hs_cnt - hb), 128'(11));

        // Backpressure for 5 cycles mid-block
        do_start({$urandom, $urandom, $urandom, $urandom}, hb);
        feed(5, 100, 1'b0, 50, acc);
        ready_mode = 2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_round", 128'(round), 128'(5));
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        ready_mode = 0;
        feed(6, 100, 1'b0, 50, acc);
        chk("bp_resume_accepts", 128'(acc), 128'(6));
        wait_done();
        chk("bp_handshakes", 128'(hs_cnt - hb), 128'(11));

        // Random blocks with random valid/ready
        for (int b = 0; b < 3; b++) begin
            ready_mode = 0;
            do_start({$urandom, $urandom, $urandom, $urandom}, hb);
            ready_mode = 1;
            feed(11, 60, 1'b0, 400, acc);
            chk("rand_accepts", 128'(acc), 128'(11));
            wait_done();
            chk("rand_handshakes", 128'(hs_cnt - hb), 128'(11));
            ready_mode = 0;
        end

        // Restart at round 4 with an output pending, then B vector under the new key
        do_start({$urandom, $urandom, $urandom, $urandom}, hb);
        feed(4, 100, 1'b0, 50, acc);
        ready_mode = 2;
        @(negedge clk);
        chk("pre_restart_round", 128'(round), 128'(4));
        @(posedge clk); #1;
        do_start(KEY_B, hb);
        chk("restart_round", 128'(round), 128'(0));
        chk("restart_out_valid", 128'(out_valid), 128'(0));
        ready_mode = 0;
        feed_one(STATE_B);
        @(posedge clk); #1;
        chk("restart_b_vector", got_out[0], EXP_B);
        feed(10, 80, 1'b0, 100, acc);
        chk("restart_accepts", 128'(acc), 128'(10));
        wait_done();
        chk("restart_handshakes", 128'(hs_cnt - hb), 128'(11));

        // Asynchronous reset mid-block
        do_start({$urandom, $urandom, $urandom, $urandom}, hb);
        feed(5, 100, 1'b0, 50, acc);
        dc = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(0));
        chk("arst_outputstate", outputstate, 128'(0));
        chk("arst_round", 128'(round), 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_done", 128'(done_cnt - dc), 128'(0));
        chk("arst_idle_in_ready", 128'(in_ready), 128'(0));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
